// File: rtl/lu_pkg.sv
// Shared definitions for the lu_pipe logic unit: operation encoding.
package lu_pkg;

    typedef logic [1:0] lu_op_t;

    localparam lu_op_t LU_OP_AND = 2'b00;
    localparam lu_op_t LU_OP_OR  = 2'b01;
    localparam lu_op_t LU_OP_XOR = 2'b10;
    localparam lu_op_t LU_OP_NOT = 2'b11;

endpackage

// File: rtl/lu_if.sv
// Operand/result handshake bundle for lu_pipe. The slave modport is the
// logic unit's view; the master modport is the producer/consumer side.
interface lu_if
    import lu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    lu_op_t           op;
    logic             acc_sel;
    logic             acc_wr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] g;
    logic             zero;
    logic             parity;

    modport master (
        output in_valid, a, b, op, acc_sel, acc_wr, out_ready,
        input  in_ready, out_valid, g, zero, parity
    );

    modport slave (
        input  in_valid, a, b, op, acc_sel, acc_wr, out_ready,
        output in_ready, out_valid, g, zero, parity
    );

endinterface

// File: rtl/lu_core.sv
// Combinational bitwise operator: AND, OR, XOR or NOT of operand A.
module lu_core
    import lu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_b,
    input  lu_op_t           i_op,
    output logic [WIDTH-1:0] o_g_next
);

    // Select the operation; b is ignored for NOT.
    always_comb begin
        o_g_next = '0;
        unique case (i_op)
            LU_OP_AND: o_g_next = i_op_a & i_b;
            LU_OP_OR:  o_g_next = i_op_a | i_b;
            LU_OP_XOR: o_g_next = i_op_a ^ i_b;
            LU_OP_NOT: o_g_next = ~i_op_a;
            default:   o_g_next = '0;
        endcase
    end

endmodule

// File: rtl/lu_pipe.sv
// Two-stage pipelined logic unit with an internal accumulator that can stand
// in for operand A. A single global stall (adv) moves both stages together.
// Optional zero/parity flags are built when LU_FLAGS_EN is defined; otherwise
// both flags are tied low.
module lu_pipe
    import lu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic clk,
    input logic rst,
    lu_if.slave bus
);

    logic             w_adv;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_g_next;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    lu_op_t           r_s1_op;
    logic             r_s1_acc_sel;
    logic             r_s1_acc_wr;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_g;

    logic [WIDTH-1:0] r_acc;

    assign w_adv        = !r_s2_valid || bus.out_ready;
    assign bus.in_ready = w_adv;

    // acc is written on the same edge the writing beat leaves S1, so the beat
    // now entering S1 always reads the updated value without forwarding.
    assign w_op_a = r_s1_acc_sel ? r_acc : r_s1_a;

    lu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_op_a   (w_op_a),
        .i_b      (r_s1_b),
        .i_op     (r_s1_op),
        .o_g_next (w_g_next)
    );

    // Stage 1: capture the offered beat whenever the pipe advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
            r_s1_op      <= LU_OP_AND;
            r_s1_acc_sel <= 1'b0;
            r_s1_acc_wr  <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid   <= bus.in_valid;
            r_s1_a       <= bus.a;
            r_s1_b       <= bus.b;
            r_s1_op      <= bus.op;
            r_s1_acc_sel <= bus.acc_sel;
            r_s1_acc_wr  <= bus.acc_wr;
        end
    end

    // Stage 2: register the result; g is don't-care for bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_g     <= '0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_g     <= w_g_next;
        end
    end

    // Accumulator: only real beats with acc_wr update it, and only on advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_adv && r_s1_valid && r_s1_acc_wr) begin
            r_acc <= w_g_next;
        end
    end

    assign bus.out_valid = r_s2_valid;
    assign bus.g         = r_s2_g;

`ifdef LU_FLAGS_EN
    logic r_s2_zero;
    logic r_s2_parity;

    // Flags are derived from g_next so they stay aligned with g in S2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_zero   <= 1'b0;
            r_s2_parity <= 1'b0;
        end else if (w_adv) begin
            r_s2_zero   <= (w_g_next == '0);
            r_s2_parity <= ^w_g_next;
        end
    end

    assign bus.zero   = r_s2_zero;
    assign bus.parity = r_s2_parity;
`else
    assign bus.zero   = 1'b0;
    assign bus.parity = 1'b0;
`endif

endmodule

// File: tb/tb_lu_pipe.sv
// Bench for lu_pipe: three instances (WIDTH 8, 1, 32) driven in lockstep with
// the same stimulus, each checked against an in-order transaction model.
module tb_lu_pipe;

    import lu_pkg::*;

    localparam int unsigned NW = 3;

`ifdef LU_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lu_if #(.WIDTH(8))  bus8  ();
    lu_if #(.WIDTH(1))  bus1  ();
    lu_if #(.WIDTH(32)) bus32 ();

    lu_pipe #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
    lu_pipe #(.WIDTH(1))  u_dut1  (.clk(clk), .rst(rst), .bus(bus1));
    lu_pipe #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    int unsigned wid [NW] = '{8, 1, 32};

    // Transaction model state per instance.
    logic [31:0] acc_m  [NW];
    logic [31:0] q      [NW][$];
    logic        held   [NW];
    logic [31:0] held_g [NW];

    // Outputs sampled at the start of the most recent step.
    logic        last_ov [NW];
    logic [31:0] last_g  [NW];
    logic        last_z  [NW];
    logic        last_p  [NW];
    logic        last_ir [NW];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [31:0] x, input logic [31:0] y,
                                           input logic [1:0] op, input int unsigned w);
        logic [31:0] m;
        logic [31:0] r;
        m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case (op)
            2'b00:   r = x & y;
            2'b01:   r = x | y;
            2'b10:   r = x ^ y;
            default: r = ~x;
        endcase
        return r & m;
    endfunction

    task automatic sample_outputs();
        last_ov[0] = bus8.out_valid;  last_g[0] = 32'(bus8.g);
        last_z[0]  = bus8.zero;       last_p[0] = bus8.parity;
        last_ov[1] = bus1.out_valid;  last_g[1] = 32'(bus1.g);
        last_z[1]  = bus1.zero;       last_p[1] = bus1.parity;
        last_ov[2] = bus32.out_valid; last_g[2] = bus32.g;
        last_z[2]  = bus32.zero;      last_p[2] = bus32.parity;
    endtask

    task automatic drive(input logic iv, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic sel, input logic wr,
                         input logic ordy);
        bus8.in_valid  = iv; bus8.a  = a[7:0]; bus8.b  = b[7:0];
        bus8.op  = op; bus8.acc_sel  = sel; bus8.acc_wr  = wr; bus8.out_ready  = ordy;
        bus1.in_valid  = iv; bus1.a  = a[0];   bus1.b  = b[0];
        bus1.op  = op; bus1.acc_sel  = sel; bus1.acc_wr  = wr; bus1.out_ready  = ordy;
        bus32.in_valid = iv; bus32.a = a;      bus32.b = b;
        bus32.op = op; bus32.acc_sel = sel; bus32.acc_wr = wr; bus32.out_ready = ordy;
    endtask

    // One clock cycle: sample, drive, check handshake and results, update model.
    task automatic step(input logic iv, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input logic sel, input logic wr,
                        input logic ordy, input logic do_rst, output logic taken);
        logic [31:0] e;
        logic [31:0] r;
        string       pfx;
        @(negedge clk);
        sample_outputs();
        for (int i = 0; i < NW; i++) begin
            if (held[i]) begin
                pfx = $sformatf("w%0d_", wid[i]);
                check({pfx, "stall_valid"}, 32'(last_ov[i]), 32'd1);
                check({pfx, "stall_g"}, last_g[i], held_g[i]);
            end
        end
        drive(iv, a, b, op, sel, wr, ordy);
        rst = do_rst;
        #1;
        last_ir[0] = bus8.in_ready;
        last_ir[1] = bus1.in_ready;
        last_ir[2] = bus32.in_ready;
        taken = iv && !do_rst && (!last_ov[0] || ordy);
        for (int i = 0; i < NW; i++) begin
            pfx = $sformatf("w%0d_", wid[i]);
            check({pfx, "in_ready"}, 32'(last_ir[i]), 32'(!last_ov[i] || ordy));
            held[i] = 1'b0;
            if (do_rst) begin
                q[i].delete();
                acc_m[i] = '0;
            end else begin
                if (last_ov[i] && ordy) begin
                    if (q[i].size() == 0) begin
                        check({pfx, "spurious_out"}, 32'(q[i].size()), 32'd1);
                    end else begin
                        e = q[i].pop_front();
                        check({pfx, "g"}, last_g[i], e);
                        check({pfx, "zero"}, 32'(last_z[i]), 32'(FLAGS_ON && (e == 32'd0)));
                        check({pfx, "parity"}, 32'(last_p[i]), 32'(FLAGS_ON && (^e)));
                    end
                end
                if (last_ov[i] && !ordy) begin
                    held[i]   = 1'b1;
                    held_g[i] = last_g[i];
                end
                if (iv && (!last_ov[i] || ordy)) begin
                    r = ref_op(sel ? acc_m[i] : a, b, op, wid[i]);
                    if (wr) acc_m[i] = r;
                    q[i].push_back(r);
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        logic t;
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, t);
    endtask

    // Reset state of all instances; leaves rst asserted for one more edge.
    task automatic chk_reset();
        @(negedge clk);
        drive(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
        #1;
        sample_outputs();
        check("rst_w8_out_valid", 32'(last_ov[0]), 32'd0);
        check("rst_w8_g", last_g[0], 32'd0);
        check("rst_w8_zero", 32'(last_z[0]), 32'd0);
        check("rst_w8_parity", 32'(last_p[0]), 32'd0);
        check("rst_w8_in_ready", 32'(bus8.in_ready), 32'd1);
        check("rst_w32_out_valid", 32'(last_ov[2]), 32'd0);
        check("rst_w32_g", last_g[2], 32'd0);
        check("rst_w1_out_valid", 32'(last_ov[1]), 32'd0);
    endtask

    logic [7:0]  ops_g  [4] = '{8'h4A, 8'hDF, 8'h95, 8'h35};
    logic        ops_ov [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0]  bp_a   [4] = '{8'h11, 8'h00, 8'h00, 8'h00};
    logic [7:0]  bp_b   [4] = '{8'h22, 8'h0F, 8'hFF, 8'h00};
    logic [1:0]  bp_op  [4] = '{2'b01, 2'b10, 2'b00, 2'b01};
    logic        bp_sel [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic        bp_wr  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        logic        t;
        int          bi;
        logic        cur_v;
        logic [31:0] cur_a, cur_b;
        logic [1:0]  cur_op;
        logic        cur_sel, cur_wr;

        rst = 1'b1;
        drive(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < NW; i++) begin
            acc_m[i] = '0;
            held[i]  = 1'b0;
        end

        step(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, t);
        step(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, t);
        chk_reset();

        // All four ops back to back; latency 2 and continuous out_valid.
        for (int k = 0; k < 7; k++) begin
            if (k < 4) step(1'b1, 32'hCA, 32'h5F, 2'(k), 1'b0, 1'b0, 1'b1, 1'b0, t);
            else       idle(1);
            check("ops_latency_ov", 32'(last_ov[0]), 32'(ops_ov[k]));
            if (k >= 2 && k < 6) check("ops_g", last_g[0], 32'(ops_g[k-2]));
        end

        // Accumulator chain: OR into acc, XOR in place, NOT of acc.
        step(1'b1, 32'hF0, 32'h3C, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, t);
        step(1'b1, 32'h00, 32'h0F, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, t);
        step(1'b1, 32'h00, 32'h00, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, t);
        check("acc_or_g", last_g[0], 32'hFC);
        idle(1);
        check("acc_xor_g", last_g[0], 32'hF3);
        idle(1);
        check("acc_not_g", last_g[0], 32'h0C);
        idle(1);

        // Backpressure: out_ready low for three cycles while four beats stream.
        bi = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (bi < 4) step(1'b1, 32'(bp_a[bi]), 32'(bp_b[bi]), bp_op[bi], bp_sel[bi],
                             bp_wr[bi], !(cyc >= 3 && cyc <= 5), 1'b0, t);
            else        step(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, t);
            if (cyc == 4) check("bp_in_ready_low", 32'(last_ir[0]), 32'd0);
            if (t) bi++;
        end
        check("bp_all_taken", 32'(bi), 32'd4);

        // Flags.
        step(1'b1, 32'hAA, 32'h55, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, t);
        step(1'b1, 32'h07, 32'h00, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, t);
        idle(1);
        check("flag_and_g", last_g[0], 32'h00);
        check("flag_and_zero", 32'(last_z[0]), 32'(FLAGS_ON));
        check("flag_and_parity", 32'(last_p[0]), 32'd0);
        idle(1);
        check("flag_not_g", last_g[0], 32'hF8);
        check("flag_not_zero", 32'(last_z[0]), 32'd0);
        check("flag_not_parity", 32'(last_p[0]), 32'(FLAGS_ON));
        idle(1);

        // Reset with both stages full and an acc_wr beat still in S1.
        step(1'b1, 32'h81, 32'h00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, t);
        step(1'b1, 32'h5A, 32'h00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, t);
        step(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, t);
        check("prefill_ov", 32'(last_ov[0]), 32'd1);
        chk_reset();
        step(1'b1, 32'h00, 32'hFF, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, t);
        step(1'b1, 32'h00, 32'h00, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, t);
        idle(1);
        check("post_rst_or_ff", last_g[0], 32'hFF);
        idle(1);
        check("post_rst_acc_zero", last_g[0], 32'h00);
        idle(1);

        // Exhaustive small sweep (covers every 1-bit combination), plus acc forms.
        for (int op = 0; op < 4; op++)
            for (int ab = 0; ab < 4; ab++)
                for (int m = 0; m < 2; m++)
                    step(1'b1, 32'(ab & 1) * 32'h5A5A_5A5B, 32'(ab >> 1) * 32'hC3C3_C3C3,
                         2'(op), 1'(m), 1'(m), 1'b1, 1'b0, t);
        idle(3);

        // Randomized traffic with backpressure and occasional reset.
        cur_v = 1'b0; cur_a = '0; cur_b = '0; cur_op = '0; cur_sel = 1'b0; cur_wr = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic rr;
            if (!cur_v) begin
                cur_v   = ($urandom_range(0, 99) < 85);
                cur_a   = $urandom;
                cur_b   = $urandom;
                cur_op  = 2'($urandom_range(0, 3));
                cur_sel = 1'($urandom_range(0, 1));
                cur_wr  = 1'($urandom_range(0, 1));
            end
            rr = ($urandom_range(0, 199) == 0);
            step(cur_v, cur_a, cur_b, cur_op, cur_sel, cur_wr,
                 ($urandom_range(0, 99) < 75), rr, t);
            if (t || rr) cur_v = 1'b0;
        end
        idle(4);
        for (int i = 0; i < NW; i++)
            check($sformatf("w%0d_drained", wid[i]), 32'(q[i].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
